// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared widths, saturation limits and state encoding for neuron_accumulator
package neuron_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } neuron_state_t;

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - clamps a wide signed value into the signed 32-bit range
module sat_clamp
  import neuron_pkg::*;
#(
  parameter int IN_WIDTH = 40
) (
  input  logic signed [IN_WIDTH-1:0]   din,
  output logic        [DATA_WIDTH-1:0] dout
);

  // Bits from the 32-bit sign position upward; the value fits when they all agree.
  logic [IN_WIDTH-DATA_WIDTH:0] upper;

  // Pass the low word through when it fits, otherwise clamp by the sign of the input.
  always_comb begin
    upper = din[IN_WIDTH-1:DATA_WIDTH-1];
    if ((&upper) || !(|upper)) begin
      dout = din[DATA_WIDTH-1:0];
    end else if (din[IN_WIDTH-1]) begin
      dout = SAT_MIN;
    end else begin
      dout = SAT_MAX;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums N_INPUTS products plus bias, saturates, optional ReLU (macro NEURON_RELU_EN)
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);

  neuron_state_t               state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
  logic        [CNT_W-1:0]     cnt, cnt_nxt;
  logic signed [ACC_WIDTH-1:0] sext_in, sext_bias;
  logic        [DATA_WIDTH-1:0] sat_val, res_val;
  logic                        beat;

  // Handshake flags decode the state register only, so no input reaches an output combinationally.
  assign in_ready  = (state != OUTPUT);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);
  assign beat      = in_valid && in_ready;

  assign sext_in   = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign sext_bias = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};

  // Next state, running sum and beat count; bias is folded in only on the first beat of a group.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (beat) begin
          acc_nxt   = sext_bias + sext_in;
          cnt_nxt   = CNT_W'(1);
          state_nxt = (N_INPUTS == 1) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_nxt = acc + sext_in;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(N_INPUTS)) begin
            state_nxt = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Saturate the sum as it will stand after this edge, so the result is ready on OUTPUT entry.
  sat_clamp #(
    .IN_WIDTH(ACC_WIDTH)
  ) u_sat (
    .din (acc_nxt),
    .dout(sat_val)
  );

  // Optional rectification of the saturated value.
  always_comb begin
`ifdef NEURON_RELU_EN
    res_val = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers; the result is captured once on entry to OUTPUT and held until the next group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if ((state != OUTPUT) && (state_nxt == OUTPUT)) begin
        out_data <= res_val;
      end
    end
  end

endmodule
